led_rgb_driver: RTL and testbench

Receiving end of the colour[2:0] code driven by the LED sequencer. It decodes each 3-bit colour code into a red/green/blue target intensity and drives three PWM LED pins. An optional linear fade ramps each channel toward its new target so colour changes are smooth rather than abrupt. It sits between the sequencer output and the board RGB LED pins.

---
 rtl/led_rgb_driver_if.sv | 29 ++
 rtl/led_rgb_driver.sv | 86 ++++++++
 tb/tb_led_rgb_driver.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/led_rgb_driver_if.sv
// rtl/led_rgb_driver_if.sv - sequencer-to-RGB-driver signal bundle
//
// Purpose: groups the colour/fade request from the LED sequencer and the
// PWM pin drives plus busy status returned by the RGB driver.
// Signals:
//   colour  [2:0] colour code from sequencer
//   fade_en       1 = ramp duties, 0 = jump at next period boundary
//   led_r/g/b     PWM pin drives, active high
//   busy          high while any channel duty differs from its target
// Modports: master = sequencer side, slave = driver side.

interface led_rgb_driver_if;
  logic [2:0] colour;
  logic       fade_en;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       busy;

  modport master (
    output colour, fade_en,
    input  led_r, led_g, led_b, busy
  );

  modport slave (
    input  colour, fade_en,
    output led_r, led_g, led_b, busy
  );
endinterface

// File: rtl/led_rgb_driver.sv
// rtl/led_rgb_driver.sv - colour-code decoder with fading three-channel PWM
//
// Purpose: registers the 3-bit colour code, decodes it into per-channel
// on/off targets and drives three PWM pins. Duty registers only move on the
// last cycle of a PWM period, either jumping to target or ramping by STEP.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   led_rgb_driver_if.slave: colour, fade_en in; led_r/g/b, busy out

module led_rgb_driver #(
  parameter int PWM_BITS = 8,
  parameter int MAX_DUTY = (1 << PWM_BITS) - 1,
  parameter int STEP     = 16
) (
  input  logic                clk,
  input  logic                rst,
  led_rgb_driver_if.slave     bus
);

  localparam logic [PWM_BITS-1:0] FULL_SCALE = '1;
  localparam logic [PWM_BITS-1:0] ON_DUTY    = PWM_BITS'(MAX_DUTY);
  localparam logic [PWM_BITS:0]   STEP_W     = (PWM_BITS+1)'(STEP);

  logic [2:0]          colour_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_q   [3];
  logic [PWM_BITS-1:0] duty_d   [3];
  logic [PWM_BITS-1:0] target   [3];
  logic [2:0]          chan_on;
  logic [2:0]          led_q;
  logic                busy_q;
  logic                boundary;

  // Channel index 0 = red, 1 = green, 2 = blue. The valid codes map bit-for-bit
  // onto {B,G,R}; only 111 breaks that and is treated as all off.
  assign chan_on  = (colour_q == 3'b111) ? 3'b000 : colour_q;
  assign boundary = (pwm_cnt_q == FULL_SCALE);

  always_comb begin
    logic [PWM_BITS:0] gap;
    gap = '0;
    for (int c = 0; c < 3; c++) begin
      target[c] = chan_on[c] ? ON_DUTY : '0;
      duty_d[c] = duty_q[c];
      if (boundary) begin
        if (!bus.fade_en) begin
          duty_d[c] = target[c];
        end else if (duty_q[c] < target[c]) begin
          // Distance to target in one extra bit so the step can never wrap.
          gap = {1'b0, target[c]} - {1'b0, duty_q[c]};
          duty_d[c] = (gap > STEP_W) ? duty_q[c] + STEP_W[PWM_BITS-1:0] : target[c];
        end else if (duty_q[c] > target[c]) begin
          gap = {1'b0, duty_q[c]} - {1'b0, target[c]};
          duty_d[c] = (gap > STEP_W) ? duty_q[c] - STEP_W[PWM_BITS-1:0] : target[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      colour_q  <= 3'b000;
      pwm_cnt_q <= '0;
      led_q     <= 3'b000;
      busy_q    <= 1'b0;
      for (int c = 0; c < 3; c++) duty_q[c] <= '0;
    end else begin
      colour_q  <= bus.colour;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      busy_q    <= (duty_q[0] != target[0]) | (duty_q[1] != target[1]) |
                   (duty_q[2] != target[2]);
      for (int c = 0; c < 3; c++) begin
        duty_q[c] <= duty_d[c];
        // Full-scale is forced on; a plain compare would leave a 1-cycle gap.
        led_q[c]  <= (duty_q[c] == FULL_SCALE) | (pwm_cnt_q < duty_q[c]);
      end
    end
  end

  assign bus.led_r = led_q[0];
  assign bus.led_g = led_q[1];
  assign bus.led_b = led_q[2];
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_rgb_driver.sv
// tb/tb_led_rgb_driver.sv - scoreboard bench for led_rgb_driver

module tb_led_rgb_driver;
  localparam int PB   = 4;
  localparam int PER  = 1 << PB;
  localparam int MAXD = PER - 1;
  localparam int STP  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_rgb_driver_if bus ();

  led_rgb_driver #(.PWM_BITS(PB), .MAX_DUTY(MAXD), .STEP(STP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  // Reference: the colour seen one clock ago selects lit channels,
  // duties move once per period, pins show the duty of the previous cycle.
  int         m_duty[3];
  int         m_cnt;
  logic [2:0] m_col;

  function automatic int lit(input logic [2:0] col, input int c);
    case (col)
      3'b001:  return (c == 0) ? 1 : 0;
      3'b010:  return (c == 1) ? 1 : 0;
      3'b011:  return (c != 2) ? 1 : 0;
      3'b100:  return (c == 2) ? 1 : 0;
      3'b101:  return (c != 1) ? 1 : 0;
      3'b110:  return (c != 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) m_duty[c] = 0;
    m_cnt = 0;
    m_col = 3'b000;
  endtask

  task automatic model_step();
    logic [3:0] e;
    int t;
    e = 4'b0000;
    if (!rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < 3; c++) begin
        t = lit(m_col, c) * MAXD;
        e[c] = (m_duty[c] == PER - 1) || (m_cnt < m_duty[c]);
        if (m_duty[c] != t) e[3] = 1'b1;
      end
      if (m_cnt == PER - 1) begin
        for (int c = 0; c < 3; c++) begin
          t = lit(m_col, c) * MAXD;
          if (!bus.fade_en)        m_duty[c] = t;
          else if (m_duty[c] < t)  m_duty[c] = (m_duty[c] + STP > t) ? t : m_duty[c] + STP;
          else if (m_duty[c] > t)  m_duty[c] = (m_duty[c] - STP < t) ? t : m_duty[c] - STP;
        end
      end
      m_cnt = (m_cnt + 1) % PER;
      m_col = bus.colour;
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic r_n, input logic [2:0] col, input logic fe);
    @(negedge clk);
    rst         = r_n;
    bus.colour  = col;
    bus.fade_en = fe;
    @(posedge clk);
    model_step();
  endtask

  // Monitor: outputs are presented every clock; compare against the queue.
  initial begin
    logic [3:0] want, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {bus.busy, bus.led_b, bus.led_g, bus.led_r};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL outputs{busy,b,g,r} t=%0t got=%b want=%b", $time, got, want);
        end
      end
    end
  end

  initial begin
    logic [2:0] col;
    logic       fe;
    logic       r_n;
    logic [2:0] sweep [8];
    sweep = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000, 3'b111, 3'b001};
    rst         = 1'b0;
    bus.colour  = 3'b001;
    bus.fade_en = 1'b0;
    model_reset();

    // Reset, then red with fade off.
    repeat (3) cycle(1'b0, 3'b001, 1'b0);
    repeat (3 * PER) cycle(1'b1, 3'b001, 1'b0);

    // Decode sweep including the invalid codes.
    for (int i = 0; i < 8; i++) repeat (2 * PER) cycle(1'b1, sweep[i], 1'b0);

    // Fade blue up, then retarget to red mid-period while rising.
    repeat (2 * PER) cycle(1'b1, 3'b000, 1'b1);
    repeat (2 * PER + 5) cycle(1'b1, 3'b100, 1'b1);
    repeat (7 * PER) cycle(1'b1, 3'b001, 1'b1);

    // Fade blue up again and reset mid-period partway through.
    repeat (PER) cycle(1'b1, 3'b000, 1'b0);
    repeat (2 * PER + 7) cycle(1'b1, 3'b100, 1'b1);
    repeat (2) cycle(1'b0, 3'b100, 1'b1);
    repeat (6 * PER) cycle(1'b1, 3'b100, 1'b1);

    // fade_en toggled mid-period only.
    repeat (PER / 2) cycle(1'b1, 3'b011, 1'b1);
    repeat (PER / 2 - 2) cycle(1'b1, 3'b011, 1'b0);
    repeat (4 * PER) cycle(1'b1, 3'b011, 1'b1);

    // Randomized traffic with occasional resets.
    col = 3'b000;
    fe  = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 23) == 0) col = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) fe = ~fe;
      r_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cycle(r_n, col, fe);
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
